// File: rtl/sat_pkg.sv
// Shared types and rail constants for the signed saturating accumulator.
package sat_pkg;

    typedef enum logic {ACCUM, RESULT} acc_state_t;

    function automatic int sat_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/signed_sat_add.sv
// Combinational N-bit two's-complement adder that clamps to the rails on overflow.
module signed_sat_add
    import sat_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         sat
);

    localparam logic [N-1:0] MaxVal = N'(sat_max(N));
    localparam logic [N-1:0] MinVal = N'(sat_min(N));

    logic [N-1:0] raw;

    always_comb begin
        raw = a + b;
        // Overflow only when operand signs agree and the result sign flips.
        sat = (a[N-1] == b[N-1]) && (raw[N-1] != a[N-1]);
        if (sat) begin
            sum = a[N-1] ? MinVal : MaxVal;
        end else begin
            sum = raw;
        end
    end

endmodule

// File: rtl/signed_sat_accumulator.sv
// Per-frame saturating accumulator with valid/ready in and a registered valid/ready result.
module signed_sat_accumulator
    import sat_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [ACC_W-1:0] down_sum,
    output logic             down_sat,
    output logic [CNT_W-1:0] down_count
);

    acc_state_t state_q, state_d;

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;

    logic [ACC_W-1:0] sample_ext;
    logic [ACC_W-1:0] next_acc;
    logic             step_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_xfer;

    assign sample_ext = ACC_W'($signed(up_data));

    signed_sat_add #(
        .N (ACC_W)
    ) u_add (
        .a   (acc_q),
        .b   (sample_ext),
        .sum (next_acc),
        .sat (step_sat)
    );

    always_comb begin
        down_valid = (state_q == RESULT);
        up_ready   = !down_valid || down_ready;
        in_xfer    = up_valid && up_ready;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        state_d    = state_q;
        unique case (state_q)
            ACCUM: begin
                if (in_xfer && up_last) state_d = RESULT;
            end
            RESULT: begin
                // A fresh last sample in the same cycle as the drain keeps the result full.
                if (!(in_xfer && up_last) && down_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            down_sum   <= '0;
            down_sat   <= 1'b0;
            down_count <= '0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                if (up_last) begin
                    down_sum   <= next_acc;
                    down_count <= cnt_inc;
                    down_sat   <= sat_q | step_sat;
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    sat_q      <= 1'b0;
                end else begin
                    acc_q <= next_acc;
                    cnt_q <= cnt_inc;
                    sat_q <= sat_q | step_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench: drives a 4-bit-accumulator and an 8-bit-accumulator instance in lockstep.
module tb_signed_sat_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up_valid = 1'b0;
    logic [3:0] up_data = '0;
    logic       up_last = 1'b0;
    logic       down_ready = 1'b1;

    logic       rdy4, vld4, sat4;
    logic [3:0] sum4;
    logic [7:0] cnt4;
    logic       rdy8, vld8, sat8;
    logic [7:0] sum8;
    logic [7:0] cnt8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signed_sat_accumulator #(.W(4), .ACC_W(4), .CNT_W(8)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (rdy4),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (vld4),
        .down_ready (down_ready),
        .down_sum   (sum4),
        .down_sat   (sat4),
        .down_count (cnt4)
    );

    signed_sat_accumulator #(.W(4), .ACC_W(8), .CNT_W(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (rdy8),
        .up_data    (up_data),
        .up_last    (up_last),
        .down_valid (vld8),
        .down_ready (down_ready),
        .down_sum   (sum8),
        .down_sat   (sat8),
        .down_count (cnt8)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat, clock it in, then settle just past the edge.
    task automatic drive(input logic v, input int d, input logic l);
        up_valid = v;
        up_data  = 4'(d);
        up_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input int s, input int sat, input int cnt);
        check_eq({tag, " vld4"}, int'(vld4), 1);
        check_eq({tag, " sum4"}, int'($signed(sum4)), s);
        check_eq({tag, " sat4"}, int'(sat4), sat);
        check_eq({tag, " cnt4"}, int'(cnt4), cnt);
    endtask

    task automatic check8(input string tag, input int s, input int sat, input int cnt);
        check_eq({tag, " vld8"}, int'(vld8), 1);
        check_eq({tag, " sum8"}, int'($signed(sum8)), s);
        check_eq({tag, " sat8"}, int'(sat8), sat);
        check_eq({tag, " cnt8"}, int'(cnt8), cnt);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, " vld4"}, int'(vld4), 0);
        check_eq({tag, " sum4"}, int'(sum4), 0);
        check_eq({tag, " sat4"}, int'(sat4), 0);
        check_eq({tag, " cnt4"}, int'(cnt4), 0);
        check_eq({tag, " vld8"}, int'(vld8), 0);
        check_eq({tag, " sum8"}, int'(sum8), 0);
        check_eq({tag, " sat8"}, int'(sat8), 0);
        check_eq({tag, " cnt8"}, int'(cnt8), 0);
    endtask

    initial begin
        #2;
        check_zero("reset");
        check_eq("reset rdy", int'(rdy4), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1,2,-1: no saturation at either width.
        drive(1, 1, 0);
        drive(1, 2, 0);
        drive(1, -1, 1);
        check4("f123", 2, 0, 3);
        check8("f123", 2, 0, 3);
        drive(0, 0, 0);
        check_eq("f123 drop", int'(vld4), 0);

        // 4,7 saturates only the 4-bit accumulator.
        drive(1, 4, 0);
        drive(1, 7, 1);
        check4("f47", 7, 1, 2);
        check8("f47", 11, 0, 2);
        drive(1, -4, 0);
        check_eq("f47 drain", int'(vld4), 0);
        drive(1, -7, 1);
        check4("fm4m7", -8, 1, 2);
        check8("fm4m7", -11, 0, 2);

        // Saturation is per step: 7+7 clamps to 7, then -8 pulls to -1.
        drive(1, 7, 0);
        drive(1, 7, 0);
        drive(1, -8, 1);
        check4("f77m8", -1, 1, 3);
        check8("f77m8", 6, 0, 3);
        drive(0, 0, 0);

        // Backpressure: result holds and no sample is taken for 5 cycles.
        down_ready = 1'b0;
        drive(1, 3, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0);
            check_eq("hold rdy", int'(rdy8), 0);
            check8("hold", 3, 0, 1);
        end
        down_ready = 1'b1;
        #1;
        check_eq("release rdy", int'(rdy8), 1);
        drive(0, 0, 0);
        check_eq("release drop", int'(vld8), 0);
        drive(1, 2, 1);
        check8("after hold", 2, 0, 1);

        // Back-to-back single-sample frames at full rate.
        drive(1, 1, 1);
        check8("b2b 1", 1, 0, 1);
        drive(1, -2, 1);
        check8("b2b -2", -2, 0, 1);
        drive(1, 5, 1);
        check8("b2b 5", 5, 0, 1);
        drive(0, 0, 0);

        // Count saturates at all-ones.
        for (int i = 0; i < 300; i++) drive(1, 0, 0);
        drive(1, 0, 1);
        check8("cnt sat", 0, 0, 255);
        drive(0, 0, 0);

        // Reset mid-frame discards the partial sum.
        drive(1, 5, 0);
        drive(1, 6, 0);
        up_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 2, 1);
        check4("post reset", 2, 0, 1);
        check8("post reset", 2, 0, 1);
        drive(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_sat_accumulator.md
Name: signed_sat_accumulator

Overview:
- Streaming stage directly downstream of the 4-bit signed saturating adder.
- Accepts a frame of signed samples over a valid/ready handshake and accumulates them with saturation at every step.
- Presents the frame total, a sticky saturation flag and a sample count on a registered valid/ready output.
- Sits between a sample source and any consumer of per-frame sums.

Parameters:
- W, 4, signed input sample width.
- ACC_W, 8, signed accumulator/result width; must be >= W.
- CNT_W, 8, width of the per-frame sample counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_valid  input  1  input sample valid.
- up_ready  output  1  block can accept a sample this cycle.
- up_data  input  W  signed two's-complement sample.
- up_last  input  1  marks the final sample of a frame; qualified by up_valid.
- down_valid  output  1  frame result valid.
- down_ready  input  1  consumer accepts the result.
- down_sum  output  ACC_W  signed saturated frame total.
- down_sat  output  1  at least one saturation occurred in the frame.
- down_count  output  CNT_W  samples in the frame; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, sat_sticky=0, down_valid=0, down_sum=0, down_sat=0, down_count=0.
- Input transfer: up_valid && up_ready. Output transfer: down_valid && down_ready.
- up_ready = !down_valid || down_ready. Combinational from down_ready; no other combinational path from inputs to outputs.
- Each step computes next = sat_add(acc, sign_extend(up_data)) at ACC_W bits:
  - Positive overflow gives 2^(ACC_W-1)-1.
  - Negative overflow gives -2^(ACC_W-1).
  - Overflow occurs only when both operands share a sign and the raw sum's sign differs.
  - Overflow sets step_sat.
- Saturation is per-step, not latched on the value: later samples of opposite sign move acc away from the rail.
- On an input transfer with up_last=0:
  - acc<=next.
  - cnt<=cnt+1, holding at all-ones.
  - sat_sticky<=sat_sticky|step_sat.
- On an input transfer with up_last=1:
  - down_sum<=next.
  - down_count<=cnt+1 (saturating).
  - down_sat<=sat_sticky|step_sat.
  - down_valid<=1.
  - acc, cnt and sat_sticky are cleared to 0 for the next frame.
- Latency: result visible the cycle after the last sample is accepted.
- down_* hold stable while down_valid=1 && down_ready=0. No input is accepted in that state.
- Output transfer with no new last sample in the same cycle: down_valid<=0. The down_sum, down_sat and down_count values are don't-care but retained.
- Simultaneous output transfer and last-sample transfer: the output register reloads with the new frame and down_valid stays 1. This supports back-to-back single-sample frames at full rate.
- Single-sample frame (up_last on the first sample): down_sum = sign-extended sample, down_count=1, down_sat=0.
- State: two-state FSM.
  - ACCUM: down_valid=0.
  - RESULT: down_valid=1.
  - ACCUM→RESULT on a last-sample transfer.
  - RESULT→ACCUM on an output transfer without a simultaneous last-sample transfer.
  - RESULT→RESULT otherwise.
- Non-last samples arriving while in RESULT with down_ready=1 are accepted and accumulate into the cleared accumulator.
- Reset asserted mid-frame or mid-hold discards the partial frame and pending result immediately.

Decomposition:
- Package sat_pkg:
  - Function sat_max(width) and sat_min(width) returning the rail constants.
  - typedef enum logic {ACCUM, RESULT} acc_state_t.
- Sub-module signed_sat_add #(N):
  - Purely combinational.
  - Inputs a, b [N-1:0]; outputs sum [N-1:0] and sat.
  - Instantiated once at N=ACC_W.
  - Unit-tested separately against the 4-bit adder's vectors at N=4.

Test Plan:
- ACC_W=4, down_ready=1, frame 1,2,-1(last) -> one cycle after the last sample: down_sum=2, down_sat=0, down_count=3, down_valid for 1 cycle.
- ACC_W=4, frame 4,7(last) -> down_sum=7, down_sat=1. Frame -4,-7(last) -> down_sum=-8, down_sat=1.
- ACC_W=4, frame 7,7,-8(last) -> acc 7, 7 (sat), -1; down_sum=-1, down_sat=1, down_count=3.
- Default params, down_ready=0 when frame 3(last) completes -> down_valid stays 1 with down_sum=3 held and up_ready=0 for 5 cycles. Raise down_ready -> single output transfer.
- Default params, down_ready=1, up_valid=1, up_last=1 every cycle with data 1,-2,5 -> down_sum 1,-2,5 on consecutive cycles, down_count=1 each, no bubbles.
- Assert rst_n=0 after samples 5,6 of an unfinished frame, release, then send 2(last) -> down_sum=2, down_count=1, down_sat=0. All outputs read 0 during reset.
